// File: rtl/shift_add_mult_if.sv
// Handshake and data bundle between the CPU datapath, the iteration counter
// and the shift-and-add multiplier.
interface shift_add_mult_if #(
  parameter int WIDTH = 16
);
  logic                 Start;
  logic [WIDTH-1:0]     Mcand;
  logic [WIDTH-1:0]     Mplier;
  logic                 K;
  logic                 Load;
  logic                 Busy;
  logic                 Done;
  logic                 Err;
  logic [2*WIDTH-1:0]   Product;

  // Requester side: issues operands, supplies the counter terminal flag.
  modport master (
    output Start, Mcand, Mplier, K,
    input  Load, Busy, Done, Err, Product
  );

  // Multiplier side.
  modport slave (
    input  Start, Mcand, Mplier, K,
    output Load, Busy, Done, Err, Product
  );
endinterface

// File: rtl/shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, one partial product per clock.
// The external counter is cleared through Load and reports the last
// iteration through K; a watchdog aborts a run whose K never arrives.
module shift_add_mult #(
  parameter int WIDTH = 16,
  parameter int WDOG  = 2 * WIDTH
) (
  input  logic              Clk,
  input  logic              Rst_n,
  shift_add_mult_if.slave   bus
);

  localparam int WD_W = $clog2(WDOG) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic               err_q, err_d;
  logic [WIDTH:0]     sum_s;

  // Accumulator plus optional multiplicand, kept one bit wider so the carry survives.
  function automatic logic [WIDTH:0] partial_sum(
    input logic [WIDTH:0]   acc,
    input logic [WIDTH-1:0] mcand,
    input logic             sel
  );
    logic [WIDTH:0] addend;
    if (sel) begin
      addend = {1'b0, mcand};
    end else begin
      addend = {(WIDTH+1){1'b0}};
    end
    return acc + addend;
  endfunction

  assign sum_s = partial_sum(a_q, b_q, q_q[0]);

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {(WIDTH+1){1'b0}};
      q_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      wd_q    <= {WD_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      b_q     <= b_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update: operand capture, iterate/shift, watchdog abort.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    b_d     = b_q;
    wd_d    = wd_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          a_d     = {(WIDTH+1){1'b0}};
          q_d     = bus.Mplier;
          b_d     = bus.Mcand;
          wd_d    = {WD_W{1'b0}};
          err_d   = 1'b0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (bus.K) begin
          // Final iteration, then present the product.
          a_d     = {1'b0, sum_s[WIDTH:1]};
          q_d     = {sum_s[0], q_q[WIDTH-1:1]};
          state_d = ST_DONE;
        end else if (wd_q == WD_W'(WDOG - 1)) begin
          // Counter never signalled the end: abandon the result.
          a_d     = {(WIDTH+1){1'b0}};
          q_d     = {WIDTH{1'b0}};
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          a_d     = {1'b0, sum_s[WIDTH:1]};
          q_d     = {sum_s[0], q_q[WIDTH-1:1]};
          wd_d    = wd_q + WD_W'(1);
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Moore-decoded status; product is taken straight from the A/Q pair.
  assign bus.Load    = (state_q != ST_RUN);
  assign bus.Busy    = (state_q == ST_RUN);
  assign bus.Done    = (state_q == ST_DONE);
  assign bus.Err     = err_q;
  assign bus.Product = {a_q[WIDTH-1:0], q_q};

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult with an attached counter model.
module tb_shift_add_mult;

  localparam int WIDTH = 16;

  logic Clk;
  logic Rst_n;
  logic force_k0;
  logic mon_en;
  logic [4:0] cnt;

  int checks;
  int failures;
  logic [31:0] exp_q[$];

  shift_add_mult_if #(.WIDTH(WIDTH)) bus ();

  shift_add_mult #(.WIDTH(WIDTH), .WDOG(2 * WIDTH)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  // Clock generation.
  always #5 Clk = ~Clk;

  // Counter model: held at zero while Load, counts otherwise.
  always @(posedge Clk) begin
    if (bus.Load) cnt <= 5'd0;
    else          cnt <= cnt + 5'd1;
  end

  assign bus.K = force_k0 ? 1'b0 : (cnt == 5'd15);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected product whenever Done is shown; checks invariants.
  always @(negedge Clk) begin
    if (mon_en) begin
      if (bus.Done) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done actual=0x%08h expected=no_done", bus.Product);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          checks++;
          if (bus.Product !== e) begin
            failures++;
            $display("FAIL product actual=0x%08h expected=0x%08h", bus.Product, e);
          end
        end
      end
      checks++;
      if (bus.Load !== ~bus.Busy) begin
        failures++;
        $display("FAIL load_vs_busy actual=%b expected=%b", bus.Load, ~bus.Busy);
      end
      checks++;
      if (bus.Done && bus.Err) begin
        failures++;
        $display("FAIL done_and_err actual=1 expected=0");
      end
    end
  end

  // Start one multiply from an idle position; returns just after E0.
  task automatic issue(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp, input bit push);
    @(posedge Clk); #1;
    bus.Start  = 1'b1;
    bus.Mcand  = a;
    bus.Mplier = b;
    if (push) exp_q.push_back(exp);
    @(posedge Clk); #1;
    bus.Start  = 1'b0;
  endtask

  // Bounded wait for Done, counting Busy cycles seen on the way.
  task automatic wait_done(input int budget, output int busy_cycles, output bit seen);
    busy_cycles = 0;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge Clk);
      if (bus.Done) seen = 1'b1;
      else if (bus.Busy) busy_cycles++;
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] p;
  } vec_t;

  initial begin
    int bc;
    bit seen;
    vec_t vecs[4];
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h0000, 16'h1234, 32'h00000000};
    vecs[3] = '{16'h1234, 16'h0001, 32'h00001234};

    Clk = 1'b0; Rst_n = 1'b0; force_k0 = 1'b0; mon_en = 1'b0;
    checks = 0; failures = 0;
    bus.Start = 1'b0; bus.Mcand = 16'h0000; bus.Mplier = 16'h0000;

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("rst_load",    {31'd0, bus.Load}, 32'd1);
    check("rst_busy",    {31'd0, bus.Busy}, 32'd0);
    check("rst_done",    {31'd0, bus.Done}, 32'd0);
    check("rst_err",     {31'd0, bus.Err},  32'd0);
    check("rst_product", bus.Product,       32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    mon_en = 1'b1;

    // Directed products with latency check.
    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].p, 1'b1);
      wait_done(40, bc, seen);
      check("done_seen", {31'd0, seen}, 32'd1);
      check("busy_cycles", bc, 32'd16);
    end

    // Start during RUN is ignored.
    issue(16'h00FF, 16'h0101, 32'h0000FFFF, 1'b1);
    repeat (4) @(posedge Clk);
    #1;
    bus.Start = 1'b1; bus.Mcand = 16'hAAAA; bus.Mplier = 16'h5555;
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    wait_done(40, bc, seen);
    check("ign_done_seen", {31'd0, seen}, 32'd1);
    @(negedge Clk);
    check("ign_idle_busy", {31'd0, bus.Busy}, 32'd0);
    check("ign_hold_product", bus.Product, 32'h0000FFFF);

    // Back-to-back: Start in the DONE cycle.
    issue(16'h1000, 16'h0010, 32'h00010000, 1'b1);
    wait_done(40, bc, seen);
    check("b2b_first_seen", {31'd0, seen}, 32'd1);
    bus.Start = 1'b1; bus.Mcand = 16'h8001; bus.Mplier = 16'h0003;
    exp_q.push_back(32'h00018003);
    @(posedge Clk); #1;
    bus.Start = 1'b0;
    @(negedge Clk);
    check("b2b_no_idle", {31'd0, bus.Busy}, 32'd1);
    wait_done(40, bc, seen);
    check("b2b_second_seen", {31'd0, seen}, 32'd1);
    check("b2b_busy_cycles", bc, 32'd15);

    // Reset in the middle of a run.
    issue(16'h1234, 16'h5678, 32'h0, 1'b0);
    repeat (7) @(posedge Clk);
    #1;
    Rst_n = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check("mid_rst_busy",    {31'd0, bus.Busy}, 32'd0);
    check("mid_rst_load",    {31'd0, bus.Load}, 32'd1);
    check("mid_rst_done",    {31'd0, bus.Done}, 32'd0);
    check("mid_rst_product", bus.Product,       32'd0);
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    repeat (20) @(negedge Clk);
    check("mid_rst_stay_idle", {31'd0, bus.Busy}, 32'd0);

    // Watchdog: K never arrives.
    force_k0 = 1'b1;
    issue(16'h0101, 16'h0202, 32'h0, 1'b0);
    bc = 0;
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge Clk);
      if (bus.Err) seen = 1'b1;
      else if (bus.Busy) bc++;
    end
    check("wdog_err_seen", {31'd0, seen}, 32'd1);
    check("wdog_run_cycles", bc, 32'd32);
    check("wdog_busy", {31'd0, bus.Busy}, 32'd0);
    check("wdog_load", {31'd0, bus.Load}, 32'd1);
    check("wdog_product", bus.Product, 32'd0);
    repeat (3) @(negedge Clk);
    check("wdog_err_sticky", {31'd0, bus.Err}, 32'd1);
    force_k0 = 1'b0;
    issue(16'h0007, 16'h0009, 32'h0000003F, 1'b1);
    @(negedge Clk);
    check("wdog_err_cleared", {31'd0, bus.Err}, 32'd0);
    wait_done(40, bc, seen);
    check("wdog_recover_seen", {31'd0, seen}, 32'd1);
    check("wdog_recover_busy", bc, 32'd15);

    repeat (3) @(negedge Clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Sequential unsigned shift-and-add multiplier that computes one partial product per clock. It sits directly downstream of the multiplier's `Counter` block. It drives that counter's `Load` input and consumes its terminal-count flag `K` to know when the last iteration is running. It takes a start/done handshake from the CPU datapath and returns a 2·WIDTH-bit product.

## Interface
- `WIDTH`, default 16: operand width in bits.
- `WDOG`, default 2·WIDTH: maximum RUN cycles without `K` before aborting.
- `Clk` input 1: system clock, rising-edge.
- `Rst_n` input 1: synchronous, active-low reset (one clock; reset is synchronous and active-low).
- `Start` input 1: request a multiply; sampled only in IDLE or DONE.
- `Mcand` input WIDTH: multiplicand, captured on an accepted `Start`.
- `Mplier` input WIDTH: multiplier, captured on an accepted `Start`.
- `K` input 1: counter terminal flag; 1 means the current RUN cycle is the last iteration.
- `Load` output 1: counter clear/hold; 1 outside RUN, 0 in RUN.
- `Busy` output 1: 1 while in RUN.
- `Done` output 1: one-cycle pulse; `Product` is valid.
- `Err` output 1: sticky watchdog error; cleared by the next accepted `Start` or by reset.
- `Product` output 2·WIDTH: result; held until the next accepted `Start`.

## Operation
- Registers:
  - B (WIDTH): latched multiplicand.
  - A (WIDTH+1): accumulator including carry.
  - Q (WIDTH): multiplier/low product.
  - wd (log2(WDOG)+1 bits): watchdog count.
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `Load`=1.
  - `Start`=1 → A←0, Q←`Mplier`, B←`Mcand`, wd←0, `Err`←0; go to RUN.
  - `K` is ignored.
- RUN:
  - `Load`=0, `Busy`=1.
  - Each edge: S = A + (Q[0] ? {0,B} : 0), computed at WIDTH+1 bits with no overflow lost.
  - Then {A,Q} ← {S,Q} >> 1, a logical shift with zero fill into the MSB of A.
  - `K`=1 at the edge → perform this final iteration, then go to DONE.
  - Otherwise wd←wd+1. When wd reaches WDOG−1 with `K`=0 → `Err`←1, A←0, Q←0, go to IDLE.
- DONE:
  - `Done`=1, `Load`=1, `Product`={A[WIDTH-1:0],Q}.
  - `Start`=1 → accepted exactly as in IDLE (back-to-back operation), go to RUN.
  - Otherwise go to IDLE.
- `Start` asserted in RUN is ignored. Operands presented then are not captured.
- `Product` is combinational from {A[WIDTH-1:0],Q}. It is valid only when `Done`=1, and stays stable in IDLE until the next accepted `Start`.

## Timing
- Reset values (`Rst_n`=0 at an edge), effective the cycle after that edge regardless of state, including mid-RUN:
  - State IDLE, `Load`=1, `Busy`=0, `Done`=0, `Err`=0.
  - A=0, Q=0, B=0, so `Product`=0.
- `Load` is Moore-decoded from state. It is never 0 outside RUN and never 1 inside RUN.
- Expected counter behaviour: it is held at 0 while `Load`=1, counts every clock while `Load`=0, and `K`=(count==WIDTH−1).
- Latency with a conforming counter:
  - `Start` is sampled at edge E0.
  - RUN occupies the cycles after E0 through E15; iterations occur at E1…E16.
  - `K`=1 during the cycle ending at E16.
  - `Done`=1 in the cycle after E16.
  - Total: `Done` is seen 16 (WIDTH) edges after E0. Throughput is one multiply per WIDTH+1 cycles back-to-back.
- If `K`=1 during the first RUN cycle, exactly one iteration is performed and the result is a partial product. This is not flagged; correct `K` timing is the counter's responsibility.
- `Done` and `Err` are never 1 in the same cycle.

## Test plan
- 3 × 5, WIDTH=16, bench counter model attached:
  - `Start` at E0.
  - `Busy`=1 for exactly 16 cycles.
  - `Done`=1 one cycle, `Product`=0x0000000F.
  - `Load`=0 exactly while `Busy`=1.
- 0xFFFF × 0xFFFF → `Product`=0xFFFE0001, which exercises carry into A[WIDTH].
- 0x0000 × 0x1234 and 0x1234 × 0x0001 → 0x00000000 and 0x00001234 respectively.
- Start handling:
  - Assert `Start` with new operands at E5 during RUN → ignored; first product unchanged.
  - Assert `Start` in the DONE cycle → second multiply begins with no IDLE cycle.
- Reset mid-operation: drive `Rst_n`=0 at E8 → next cycle IDLE, `Busy`=0, `Load`=1, `Product`=0, no `Done` pulse.
- Watchdog: tie `K`=0 → after 32 RUN cycles, `Err`=1 and FSM returns to IDLE with no `Done`. A following `Start` clears `Err` and the multiply completes normally.
